// File: rtl/ape_enc.sv
// APE authenticated-encryption engine, 34-bit rate / 16-bit capacity (50-bit state).
// Absorbs plaintext blocks, emits one ciphertext block each, then holds the tag.
module ape_enc (
    input  logic        clk,
    input  logic        error,
    input  logic [63:0] key_i,
    input  logic        start_i,
    input  logic [33:0] ptext_i,
    input  logic        plast_i,
    input  logic        pvalid_i,
    output logic        pready_o,
    output logic [33:0] ctext_o,
    output logic        cvalid_o,
    input  logic        cready_i,
    output logic [15:0] tag_o,
    output logic        tag_valid_o,
    output logic        busy_o
);

    localparam logic [33:0] IV = 34'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABSORB = 2'd1,
        OUT    = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Per-round constants for the four Feistel rounds of the permutation.
    function automatic logic [24:0] round_const(input logic [1:0] rnd);
        logic [24:0] rc;
        case (rnd)
            2'd0:    rc = 25'h0A5F0C3;
            2'd1:    rc = 25'h13C96E1;
            2'd2:    rc = 25'h1F0E2D5;
            2'd3:    rc = 25'h0725B79;
            default: rc = 25'h0000000;
        endcase
        return rc;
    endfunction

    // Forward permutation: 4-round Feistel on 25-bit halves, so the decryptor
    // can invert it round by round with the same round function.
    function automatic logic [49:0] ape_perm(input logic [49:0] s);
        logic [24:0] l;
        logic [24:0] r;
        logic [24:0] t;
        l = s[49:25];
        r = s[24:0];
        for (int i = 0; i < 4; i++) begin
            t = l ^ ({r[19:0], r[24:20]} & {r[13:0], r[24:14]})
                  ^ {r[23:0], r[24]} ^ round_const(2'(i));
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    state_e      state_q, state_d;
    logic [49:0] st_q, st_d;
    logic [15:0] key_q, key_d;
    logic [33:0] ctext_q, ctext_d;
    logic        last_q, last_d;
    logic [49:0] perm_out_s;

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        key_d      = key_q;
        ctext_d    = ctext_q;
        last_d     = last_q;
        perm_out_s = ape_perm({st_q[49:16] ^ ptext_i, st_q[15:0]});
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    st_d    = {IV, key_i[15:0]};
                    key_d   = key_i[15:0];
                    state_d = ABSORB;
                end else begin
                    state_d = state_q;
                end
            end
            ABSORB: begin
                if (pvalid_i) begin
                    st_d    = perm_out_s;
                    ctext_d = perm_out_s[49:16];
                    last_d  = plast_i;
                    state_d = OUT;
                end else begin
                    state_d = ABSORB;
                end
            end
            OUT: begin
                if (cready_i) begin
                    state_d = last_q ? DONE : ABSORB;
                end else begin
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (error) begin
            state_q <= IDLE;
            st_q    <= 50'h0;
            key_q   <= 16'h0;
            ctext_q <= 34'h0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            ctext_q <= ctext_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode registered state only; data buses are zero when not valid.
    always_comb begin
        pready_o    = (state_q == ABSORB);
        cvalid_o    = (state_q == OUT);
        tag_valid_o = (state_q == DONE);
        busy_o      = (state_q == ABSORB) || (state_q == OUT);
        ctext_o     = cvalid_o ? ctext_q : 34'h0;
        tag_o       = tag_valid_o ? (st_q[15:0] ^ key_q) : 16'h0;
    end

endmodule

// File: tb/tb_ape_enc.sv
// Self-checking bench for ape_enc: directed scenarios plus randomized messages
// checked against a bit-level Feistel model and an inverse-permutation decryptor.
module tb_ape_enc;

    logic        clk = 1'b0;
    logic        error;
    logic [63:0] key_i;
    logic        start_i;
    logic [33:0] ptext_i;
    logic        plast_i;
    logic        pvalid_i;
    logic        pready_o;
    logic [33:0] ctext_o;
    logic        cvalid_o;
    logic        cready_i;
    logic [15:0] tag_o;
    logic        tag_valid_o;
    logic        busy_o;

    ape_enc dut (
        .clk(clk), .error(error), .key_i(key_i), .start_i(start_i),
        .ptext_i(ptext_i), .plast_i(plast_i), .pvalid_i(pvalid_i),
        .pready_o(pready_o), .ctext_o(ctext_o), .cvalid_o(cvalid_o),
        .cready_i(cready_i), .tag_o(tag_o), .tag_valid_o(tag_valid_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [24:0] rcs [4] = '{25'h0A5F0C3, 25'h13C96E1, 25'h1F0E2D5, 25'h0725B79};

    // message under test and observations
    logic [63:0] mkey;
    int          nblk;
    logic [33:0] blk     [8];
    logic [33:0] exp_c   [8];
    logic [15:0] exp_tag;
    logic [33:0] obs_c   [8];
    logic [15:0] obs_tag;
    logic        obs_tv;
    logic        obs_start_pready;
    logic        obs_start_tv;
    bit          run_ok;
    logic [33:0] rec_p   [8];
    logic [15:0] rec_key;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Round function, bit by bit: f[i] = r[i-5] & r[i-11] ^ r[i-1] ^ rc[i].
    function automatic logic [24:0] fm(input logic [24:0] r, input int k);
        logic [24:0] f;
        for (int i = 0; i < 25; i++)
            f[i] = (r[(i + 20) % 25] & r[(i + 14) % 25]) ^ r[(i + 24) % 25] ^ rcs[k][i];
        return f;
    endfunction

    function automatic logic [49:0] perm_m(input logic [49:0] s);
        logic [24:0] l, r, t;
        l = s[49:25]; r = s[24:0];
        for (int k = 0; k < 4; k++) begin
            t = l ^ fm(r, k); l = r; r = t;
        end
        return {l, r};
    endfunction

    function automatic logic [49:0] perm_inv(input logic [49:0] s);
        logic [24:0] l, r, t;
        l = s[49:25]; r = s[24:0];
        for (int k = 3; k >= 0; k--) begin
            t = r ^ fm(l, k); r = l; l = t;
        end
        return {l, r};
    endfunction

    task automatic model_msg;
        logic [49:0] s;
        s = {34'h0, mkey[15:0]};
        for (int i = 0; i < nblk; i++) begin
            s = perm_m({s[49:16] ^ blk[i], s[15:0]});
            exp_c[i] = s[49:16];
        end
        exp_tag = s[15:0] ^ mkey[15:0];
    endtask

    // Decrypt observed ciphertexts + tag by walking the permutation backwards.
    task automatic decrypt_obs;
        logic [49:0] s, x;
        logic [33:0] prev;
        s = {obs_c[nblk-1], obs_tag ^ mkey[15:0]};
        for (int i = nblk - 1; i >= 0; i--) begin
            x = perm_inv(s);
            prev = (i == 0) ? 34'h0 : obs_c[i-1];
            rec_p[i] = x[49:16] ^ prev;
            s = {prev, x[15:0]};
        end
        rec_key = s[15:0];
    endtask

    // Drives one full message from IDLE/DONE; records observations only.
    task automatic run_msg(input bit rnd, input bit poke);
        int budget;
        run_ok = 1'b1;
        start_i = 1'b1; key_i = mkey;
        tick;
        start_i = 1'b0;
        obs_start_pready = pready_o;
        obs_start_tv = tag_valid_o;
        for (int i = 0; i < nblk; i++) begin
            if (rnd) begin
                pvalid_i = 1'b0;
                repeat ($urandom_range(0, 2)) tick;
            end
            ptext_i = blk[i]; plast_i = (i == nblk - 1); pvalid_i = 1'b1;
            if (poke) begin start_i = 1'b1; key_i = 64'hFFFF; end
            budget = 0;
            while (!pready_o && budget < 20) begin tick; budget++; end
            if (budget >= 20) run_ok = 1'b0;
            tick;
            pvalid_i = 1'b0; start_i = 1'b0; ptext_i = $urandom;
            if (!cvalid_o) run_ok = 1'b0;
            obs_c[i] = ctext_o;
            if (rnd) begin
                cready_i = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    tick;
                    if (ctext_o !== obs_c[i] || !cvalid_o || pready_o) run_ok = 1'b0;
                end
            end
            if (poke) begin start_i = 1'b1; key_i = 64'hFFFF; end
            cready_i = 1'b1;
            tick;
            cready_i = 1'b0; start_i = 1'b0; key_i = mkey;
        end
        obs_tag = tag_o;
        obs_tv = tag_valid_o;
    endtask

    task automatic test_reset;
        error = 1'b1;
        tick; tick;
        error = 1'b0;
        checks++;
        if ({pready_o, cvalid_o, ctext_o, tag_o, tag_valid_o, busy_o} !== 54'h0) begin
            errors++;
            $display("FAIL reset_init: outputs=%h required 0",
                     {pready_o, cvalid_o, ctext_o, tag_o, tag_valid_o, busy_o});
        end
        start_i = 1'b1; key_i = {$urandom, $urandom};
        tick;
        start_i = 1'b0;
        checks++;
        if (pready_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_absorb: pready=%b busy=%b required 1 1", pready_o, busy_o);
        end
        ptext_i = $urandom; pvalid_i = 1'b1; plast_i = 1'b0; error = 1'b1;
        tick; tick;
        error = 1'b0;
        checks++;
        if ({pready_o, cvalid_o, ctext_o, tag_o, tag_valid_o, busy_o} !== 54'h0) begin
            errors++;
            $display("FAIL reset_mid: outputs=%h required 0",
                     {pready_o, cvalid_o, ctext_o, tag_o, tag_valid_o, busy_o});
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (pready_o !== 1'b0 || cvalid_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_hold: pready=%b cvalid=%b busy=%b required 0 0 0",
                         pready_o, cvalid_o, busy_o);
            end
        end
        pvalid_i = 1'b0;
    endtask

    task automatic test_single;
        mkey = 64'h0123_4567_89AB_CDEF; nblk = 1; blk[0] = 34'h0;
        model_msg();
        run_msg(1'b0, 1'b0);
        checks++;
        if (!run_ok) begin errors++; $display("FAIL single_handshake: ok=%b required 1", run_ok); end
        checks++;
        if (obs_c[0] !== exp_c[0]) begin
            errors++; $display("FAIL single_ctext: got %h required %h", obs_c[0], exp_c[0]);
        end
        checks++;
        if (obs_tv !== 1'b1 || obs_tag !== exp_tag) begin
            errors++; $display("FAIL single_tag: got %b/%h required 1/%h", obs_tv, obs_tag, exp_tag);
        end
        checks++;
        if (ctext_o !== 34'h0 || cvalid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL single_done_out: ctext=%h cvalid=%b busy=%b required 0", ctext_o, cvalid_o, busy_o);
        end
    endtask

    task automatic test_four_block;
        mkey = {$urandom, $urandom}; nblk = 4;
        blk[0] = 34'h1; blk[1] = 34'h2; blk[2] = 34'h3_FFFF_FFFF; blk[3] = 34'h0;
        model_msg();
        run_msg(1'b0, 1'b0);
        checks++;
        if (!run_ok) begin errors++; $display("FAIL four_handshake: ok=%b required 1", run_ok); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_c[i] !== exp_c[i]) begin
                errors++; $display("FAIL four_ctext%0d: got %h required %h", i, obs_c[i], exp_c[i]);
            end
        end
        checks++;
        if (obs_tag !== exp_tag || obs_tv !== 1'b1) begin
            errors++; $display("FAIL four_tag: got %b/%h required 1/%h", obs_tv, obs_tag, exp_tag);
        end
        decrypt_obs();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rec_p[i] !== blk[i]) begin
                errors++; $display("FAIL four_decrypt%0d: got %h required %h", i, rec_p[i], blk[i]);
            end
        end
        checks++;
        if (rec_key !== mkey[15:0]) begin
            errors++; $display("FAIL four_decrypt_key: got %h required %h", rec_key, mkey[15:0]);
        end
    endtask

    task automatic test_backpressure;
        mkey = {$urandom, $urandom}; nblk = 2;
        blk[0] = {$urandom, 2'b01}; blk[1] = {$urandom, 2'b10};
        model_msg();
        start_i = 1'b1; key_i = mkey;
        tick;
        start_i = 1'b0;
        ptext_i = blk[0]; plast_i = 1'b0; pvalid_i = 1'b1; cready_i = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            ptext_i = {$urandom, 2'b11}; plast_i = 1'b1; pvalid_i = 1'b1;
            checks++;
            if (ctext_o !== exp_c[0] || cvalid_o !== 1'b1 || pready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: ctext=%h cvalid=%b pready=%b required %h 1 0",
                         i, ctext_o, cvalid_o, pready_o, exp_c[0]);
            end
            tick;
        end
        pvalid_i = 1'b0; cready_i = 1'b1;
        tick;
        cready_i = 1'b0;
        checks++;
        if (pready_o !== 1'b1 || cvalid_o !== 1'b0) begin
            errors++; $display("FAIL bp_release: pready=%b cvalid=%b required 1 0", pready_o, cvalid_o);
        end
        ptext_i = blk[1]; plast_i = 1'b1; pvalid_i = 1'b1;
        tick;
        pvalid_i = 1'b0;
        checks++;
        if (cvalid_o !== 1'b1 || ctext_o !== exp_c[1]) begin
            errors++; $display("FAIL bp_second: cvalid=%b ctext=%h required 1 %h", cvalid_o, ctext_o, exp_c[1]);
        end
        cready_i = 1'b1;
        tick;
        cready_i = 1'b0;
        checks++;
        if (tag_valid_o !== 1'b1 || tag_o !== exp_tag) begin
            errors++; $display("FAIL bp_tag: got %b/%h required 1/%h", tag_valid_o, tag_o, exp_tag);
        end
    endtask

    task automatic test_ignored_start;
        mkey = 64'h0123_4567_89AB_CDEF; nblk = 3;
        for (int i = 0; i < 3; i++) blk[i] = {$urandom, 2'b10};
        model_msg();
        run_msg(1'b0, 1'b1);
        checks++;
        if (!run_ok) begin errors++; $display("FAIL ign_handshake: ok=%b required 1", run_ok); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_c[i] !== exp_c[i]) begin
                errors++; $display("FAIL ign_ctext%0d: got %h required %h", i, obs_c[i], exp_c[i]);
            end
        end
        checks++;
        if (obs_tag !== exp_tag || obs_tv !== 1'b1) begin
            errors++; $display("FAIL ign_tag: got %b/%h required 1/%h", obs_tv, obs_tag, exp_tag);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] first_tag;
        first_tag = obs_tag;
        run_msg(1'b1, 1'b0);
        checks++;
        if (obs_start_tv !== 1'b0 || obs_start_pready !== 1'b1) begin
            errors++; $display("FAIL b2b_restart: tag_valid=%b pready=%b required 0 1", obs_start_tv, obs_start_pready);
        end
        checks++;
        if (obs_tag !== first_tag || obs_tv !== 1'b1) begin
            errors++; $display("FAIL b2b_tag: got %b/%h required 1/%h", obs_tv, obs_tag, first_tag);
        end
    endtask

    task automatic test_random;
        for (int m = 0; m < 6; m++) begin
            mkey = {$urandom, $urandom}; nblk = $urandom_range(1, 6);
            for (int i = 0; i < nblk; i++) blk[i] = {$urandom, 2'($urandom)};
            model_msg();
            run_msg(1'b1, 1'b0);
            checks++;
            if (!run_ok) begin errors++; $display("FAIL rnd%0d_handshake: ok=%b required 1", m, run_ok); end
            for (int i = 0; i < nblk; i++) begin
                checks++;
                if (obs_c[i] !== exp_c[i]) begin
                    errors++; $display("FAIL rnd%0d_ctext%0d: got %h required %h", m, i, obs_c[i], exp_c[i]);
                end
            end
            checks++;
            if (obs_tag !== exp_tag || obs_tv !== 1'b1) begin
                errors++; $display("FAIL rnd%0d_tag: got %b/%h required 1/%h", m, obs_tv, obs_tag, exp_tag);
            end
        end
    endtask

    initial begin
        error = 1'b1; key_i = 64'h0; start_i = 1'b0; ptext_i = 34'h0;
        plast_i = 1'b0; pvalid_i = 1'b0; cready_i = 1'b0;
        test_reset();
        test_single();
        test_four_block();
        test_back_to_back();
        test_backpressure();
        test_ignored_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
